// File: rtl/i2c_rpt_pkg.sv
// Shared types and helpers for the I2C repeater/fan-out.
// Latency: n/a (types only).
// Backpressure: n/a.
package i2c_rpt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DOWN  = 2'd1,
        UP    = 2'd2,
        GUARD = 2'd3
    } sda_dir_t;

    localparam logic SDA_RELEASE = 1'b1;

    function automatic int guard_cnt_w(input int guard_cyc);
        return $clog2(guard_cyc + 1);
    endfunction

endpackage

// File: rtl/i2c_glitch_filt.sv
// Two-flop synchroniser plus run-length glitch filter for one I2C line.
// Latency: 2 + FILT_LEN cycles from pin change to dout change.
// Backpressure: none, free-running; pulses shorter than FILT_LEN are dropped.
module i2c_glitch_filt #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic       sync_q1;
    logic       sync_q2;
    logic [3:0] run_cnt;

    // run_cnt counts consecutive synchronised samples that disagree with dout
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            run_cnt <= '0;
            dout    <= 1'b1;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
            if (sync_q2 == dout) begin
                run_cnt <= '0;
            end else if (run_cnt == 4'(FILT_LEN - 1)) begin
                dout    <= sync_q2;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_rpt_nch.sv
// I2C repeater: one upstream bus fanned out to NCH downstream buses.
// Latency: filtered line +1 cycle for SCL, +2 cycles for SDA direction changes.
// Backpressure: none; no clock stretching, downstream SCL is never read back.
module i2c_rpt_nch
    import i2c_rpt_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int FILT_LEN  = 4,
    parameter int GUARD_CYC = 8,
    parameter int HB_BITS   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_scl_i,
    input  logic             s_sda_i,
    output logic             s_sda_o,
    output logic [NCH-1:0]   m_scl_o,
    input  logic [NCH-1:0]   m_sda_i,
    output logic [NCH-1:0]   m_sda_o,
    input  logic [NCH-1:0]   ch_en,
    output logic             busy,
    output logic [15:0]      start_cnt,
    output logic             led
);

    localparam int GCNT_W = guard_cnt_w(GUARD_CYC);

    logic               scl_f;
    logic               sda_f_up;
    logic [NCH-1:0]     m_sda_f;
    logic               sda_f_q;
    logic               start_det;
    logic               stop_det;
    logic [NCH-1:0]     act_mask;
    logic [HB_BITS-1:0] hb_cnt;
    logic [GCNT_W-1:0]  gcnt;
    logic               guard_done;
    logic               up_req;
    sda_dir_t           state;
    sda_dir_t           state_nxt;
    logic               s_sda_nxt;
    logic [NCH-1:0]     m_sda_nxt;

    i2c_glitch_filt #(.FILT_LEN(FILT_LEN)) u_filt_scl (
        .clk  (clk),
        .rst  (rst),
        .din  (s_scl_i),
        .dout (scl_f)
    );

    i2c_glitch_filt #(.FILT_LEN(FILT_LEN)) u_filt_sda (
        .clk  (clk),
        .rst  (rst),
        .din  (s_sda_i),
        .dout (sda_f_up)
    );

    for (genvar i = 0; i < NCH; i++) begin : g_ch_filt
        i2c_glitch_filt #(.FILT_LEN(FILT_LEN)) u_filt_msda (
            .clk  (clk),
            .rst  (rst),
            .din  (m_sda_i[i]),
            .dout (m_sda_f[i])
        );
    end

    assign start_det = scl_f & sda_f_q & ~sda_f_up;
    assign stop_det  = scl_f & ~sda_f_q & sda_f_up;

    // Channel mask is only reloaded at (repeated) START
    always_ff @(posedge clk) begin
        if (rst) begin
            sda_f_q   <= 1'b1;
            busy      <= 1'b0;
            start_cnt <= '0;
            act_mask  <= '0;
            m_scl_o   <= '1;
            hb_cnt    <= '0;
        end else begin
            sda_f_q <= sda_f_up;
            hb_cnt  <= hb_cnt + HB_BITS'(1);
            m_scl_o <= ~act_mask | {NCH{scl_f}};
            if (start_det) begin
                busy      <= 1'b1;
                start_cnt <= start_cnt + 16'd1;
                act_mask  <= ch_en;
            end else if (stop_det) begin
                busy <= 1'b0;
            end
        end
    end

    assign up_req     = |(act_mask & ~m_sda_f);
    assign guard_done = (gcnt == GCNT_W'(GUARD_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state != GUARD) begin
            gcnt <= '0;
        end else begin
            gcnt <= gcnt + GCNT_W'(1);
        end
    end

    // Upstream low has priority so a master drive is never overridden by a slave
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!sda_f_up) begin
                    state_nxt = DOWN;
                end else if (up_req) begin
                    state_nxt = UP;
                end
            end
            DOWN:    if (sda_f_up) state_nxt = GUARD;
            UP:      if (!up_req) state_nxt = GUARD;
            GUARD:   if (guard_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_sda_nxt = SDA_RELEASE;
        m_sda_nxt = {NCH{SDA_RELEASE}};
        case (state)
            DOWN:    m_sda_nxt = ~act_mask;
            UP:      s_sda_nxt = ~SDA_RELEASE;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_sda_o <= SDA_RELEASE;
            m_sda_o <= {NCH{SDA_RELEASE}};
        end else begin
            s_sda_o <= s_sda_nxt;
            m_sda_o <= m_sda_nxt;
        end
    end

    assign led = hb_cnt[HB_BITS-1] ^ (state == UP);

endmodule

// File: tb/tb_i2c_rpt_nch.sv
// Bench for the I2C repeater: directed bus scenarios plus random line activity.
// A cycle-level reference model built from filter windows and timestamps is
// compared against every output once per clock.
module tb_i2c_rpt_nch;

    localparam int NCH       = 2;
    localparam int FILT_LEN  = 4;
    localparam int GUARD_CYC = 8;
    localparam int HB_BITS   = 8;
    localparam int NL        = NCH + 2;
    localparam int HL        = FILT_LEN + 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           s_scl_i = 1'b1;
    logic           s_sda_i = 1'b1;
    logic           s_sda_o;
    logic [NCH-1:0] m_scl_o;
    logic [NCH-1:0] m_sda_i = '1;
    logic [NCH-1:0] m_sda_o;
    logic [NCH-1:0] ch_en = 2'b11;
    logic           busy;
    logic [15:0]    start_cnt;
    logic           led;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    i2c_rpt_nch #(
        .NCH       (NCH),
        .FILT_LEN  (FILT_LEN),
        .GUARD_CYC (GUARD_CYC),
        .HB_BITS   (HB_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_scl_i   (s_scl_i),
        .s_sda_i   (s_sda_i),
        .s_sda_o   (s_sda_o),
        .m_scl_o   (m_scl_o),
        .m_sda_i   (m_sda_i),
        .m_sda_o   (m_sda_o),
        .ch_en     (ch_en),
        .busy      (busy),
        .start_cnt (start_cnt),
        .led       (led)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Reference model. Lines: 0 = SCL, 1 = upstream SDA, 2.. = downstream SDA.
    // hist[l][d] is the pin level captured d edges ago.
    logic [HL-1:0]       hist [NL];
    logic [NL-1:0]       filt;
    logic [NL-1:0]       pin;
    logic [FILT_LEN-1:0] win;
    logic [NCH-1:0]      mf, pend, act;
    logic                sda_prev, start_ev, stop_ev;
    int                  dir;   // 0 idle, 1 master->slaves, 2 slave->master, 3 guard
    int                  cyc, g_exit;
    logic                e_busy, e_s_sda, e_led;
    logic [15:0]         e_cnt;
    logic [NCH-1:0]      e_m_sda, e_m_scl;

    always @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < NL; l++) hist[l] = '1;
            filt     = '1;
            sda_prev = 1'b1;
            dir      = 0;
            cyc      = 0;
            g_exit   = 0;
            act      = '0;
            e_busy   = 1'b0;
            e_cnt    = '0;
            e_s_sda  = 1'b1;
            e_m_sda  = '1;
            e_m_scl  = '1;
            e_led    = 1'b0;
        end else begin
            pin  = {m_sda_i, s_sda_i, s_scl_i};
            mf   = filt[NL-1:2];
            pend = act & ~mf;
            e_s_sda = (dir != 2);
            e_m_sda = (dir == 1) ? ~act : '1;
            for (int i = 0; i < NCH; i++) e_m_scl[i] = act[i] ? filt[0] : 1'b1;
            start_ev = filt[0] && sda_prev && !filt[1];
            stop_ev  = filt[0] && !sda_prev && filt[1];
            sda_prev = filt[1];
            cyc++;
            case (dir)
                0: begin
                    if (!filt[1]) dir = 1;
                    else if (pend != '0) dir = 2;
                end
                1: if (filt[1]) begin dir = 3; g_exit = cyc + GUARD_CYC; end
                2: if (pend == '0) begin dir = 3; g_exit = cyc + GUARD_CYC; end
                default: if (cyc == g_exit) dir = 0;
            endcase
            if (start_ev) begin
                e_busy = 1'b1;
                e_cnt++;
                act = ch_en;
            end else if (stop_ev) begin
                e_busy = 1'b0;
            end
            e_led = cyc[HB_BITS-1] ^ (dir == 2);
            for (int l = 0; l < NL; l++) begin
                hist[l] = {hist[l][HL-2:0], pin[l]};
                win = hist[l][FILT_LEN+1:2];
                if (&win) filt[l] = 1'b1;
                else if (!(|win)) filt[l] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("m_s_sda_o", s_sda_o, e_s_sda);
        chk("m_m_sda_o", m_sda_o, e_m_sda);
        chk("m_m_scl_o", m_scl_o, e_m_scl);
        chk("m_busy", busy, e_busy);
        chk("m_start_cnt", start_cnt, e_cnt);
        chk("m_led", led, e_led);
    end

    logic [1:0] cur_en;

    task automatic send_bit(input logic b);
        logic [1:0] exp_scl, exp_sda;
        exp_scl = ~cur_en;
        exp_sda = b ? 2'b11 : ~cur_en;
        s_scl_i = 1'b0;
        tick(8);
        s_sda_i = b;
        tick(8);
        chk("bit_scl_low", m_scl_o, exp_scl);
        s_scl_i = 1'b1;
        tick(16);
        chk("bit_sda", m_sda_o, exp_sda);
        chk("bit_s_sda", s_sda_o, 1);
    endtask

    initial begin
        logic [7:0] byte_v;
        cur_en = 2'b01;
        byte_v = 8'hA5;

        tick(3);
        chk("rst_s_sda", s_sda_o, 1);
        chk("rst_m_sda", m_sda_o, 2'b11);
        chk("rst_m_scl", m_scl_o, 2'b11);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", start_cnt, 0);
        chk("rst_led", led, 0);
        rst = 1'b0;
        tick(127);
        chk("led_127", led, 0);
        tick(1);
        chk("led_128", led, 1);
        tick(127);
        chk("led_255", led, 1);

        // Glitches on upstream SDA with SCL high
        s_sda_i = 1'b0;
        tick(3);
        s_sda_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk("glitch3_m_sda", m_sda_o, 2'b11);
        end
        chk("glitch3_cnt", start_cnt, 0);
        s_sda_i = 1'b0;
        tick(4);
        s_sda_i = 1'b1;
        tick(3);
        chk("glitch4_pre", m_sda_o, 2'b11);
        tick(1);
        chk("glitch4_m_sda", m_sda_o, 2'b00);
        chk("glitch4_busy", busy, 1);
        tick(30);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(10);

        // START on channel 0, byte 0xA5
        ch_en   = 2'b01;
        s_sda_i = 1'b0;
        tick(16);
        chk("start_busy", busy, 1);
        chk("start_cnt1", start_cnt, 1);
        for (int k = 7; k >= 0; k--) send_bit(byte_v[k]);

        // ACK from slave 0, then a re-pull during guard
        s_scl_i = 1'b0;
        tick(4);
        m_sda_i[0] = 1'b0;
        tick(12);
        chk("ack_up_s", s_sda_o, 0);
        chk("ack_up_m", m_sda_o, 2'b11);
        s_scl_i = 1'b1;
        tick(16);
        s_scl_i = 1'b0;
        tick(4);
        m_sda_i[0] = 1'b1;
        tick(7);
        chk("ack_hold", s_sda_o, 0);
        tick(1);
        chk("ack_rel", s_sda_o, 1);
        m_sda_i[0] = 1'b0;
        tick(8);
        chk("guard_hold", s_sda_o, 1);
        tick(1);
        chk("guard_exit", s_sda_o, 0);
        m_sda_i[0] = 1'b1;
        tick(30);

        // Simultaneous low: master wins
        s_sda_i    = 1'b0;
        m_sda_i[0] = 1'b0;
        tick(12);
        chk("simul_s_sda", s_sda_o, 1);
        chk("simul_m_sda", m_sda_o, 2'b10);
        s_sda_i    = 1'b1;
        m_sda_i[0] = 1'b1;
        tick(30);

        // Repeated START onto channel 1, then STOP
        s_scl_i = 1'b1;
        tick(16);
        ch_en   = 2'b10;
        s_sda_i = 1'b0;
        tick(16);
        chk("rs_cnt", start_cnt, 2);
        chk("rs_busy", busy, 1);
        ch_en   = 2'b11;
        s_scl_i = 1'b0;
        tick(16);
        chk("rs_m_scl", m_scl_o, 2'b01);
        chk("rs_m_sda", m_sda_o, 2'b01);
        s_scl_i = 1'b1;
        tick(16);
        s_sda_i = 1'b1;
        tick(16);
        chk("stop_busy", busy, 0);

        // Reset in the middle of a byte
        ch_en   = 2'b01;
        cur_en  = 2'b01;
        s_sda_i = 1'b0;
        tick(16);
        chk("start_cnt3", start_cnt, 3);
        send_bit(1'b0);
        s_scl_i = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_s_sda", s_sda_o, 1);
        chk("mid_rst_m_sda", m_sda_o, 2'b11);
        chk("mid_rst_m_scl", m_scl_o, 2'b11);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", start_cnt, 0);
        rst = 1'b0;
        tick(20);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_m_sda", m_sda_o, 2'b11);
        s_sda_i = 1'b1;
        tick(10);
        s_scl_i = 1'b1;
        tick(30);

        // Random line activity, including sub-filter glitches and resets
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(5) == 0) s_scl_i = ~s_scl_i;
            if ($urandom_range(5) == 0) s_sda_i = ~s_sda_i;
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(7) == 0) m_sda_i[i] = ~m_sda_i[i];
            end
            if ($urandom_range(19) == 0) ch_en = NCH'($urandom);
            rst = ($urandom_range(499) == 0);
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
